icap_arbiter: RTL and testbench

Owner of the ICAPE3 configuration port. Shares it between two streaming requesters, such as a partial-reconfiguration loader and a readback/status client, using round-robin arbitration at burst granularity. Adds a non-maskable warm-boot (IPROG) path for the thermal/reset supervisor. Drives CSIB/RDWRB/I directly (per-byte bit-swapped, registered), so the top level only instantiates ICAPE3 and wires it.

---
 rtl/icap_pkg.sv | 32 +++
 rtl/icap_iprog_seq.sv | 56 +++++
 rtl/icap_arbiter.sv | 152 +++++++++++++++
 tb/tb_icap_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icap_pkg.sv
// Shared types, IPROG command words and helpers for the ICAPE3 arbiter.
package icap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_XFER,
    ST_GAP,
    ST_IPROG,
    ST_HALT
  } state_t;

  // Warm-boot command words in normal (unswapped) bit order
  localparam logic [31:0] DUMMY     = 32'hFFFF_FFFF;
  localparam logic [31:0] SYNC      = 32'hAA99_5566;
  localparam logic [31:0] NOOP      = 32'h2000_0000;
  localparam logic [31:0] WR_WBSTAR = 32'h3002_0001;
  localparam logic [31:0] WR_CMD    = 32'h3000_8001;
  localparam logic [31:0] CMD_IPROG = 32'h0000_000F;

  // ICAPE3 expects every byte with its bit order reversed
  function automatic logic [31:0] bitswap32(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 8; j++) begin
        r[8*k + j] = d[8*k + 7 - j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/icap_iprog_seq.sv
// Steps through the eight-word IPROG warm-boot sequence, one word per cycle.
module icap_iprog_seq
  import icap_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] wbstar,
  output logic [31:0] word,
  output logic        valid,
  output logic        done
);

  logic [2:0]  idx;
  logic        active;
  logic [31:0] wbstar_q;

  // Latch the boot address on start, then walk the index once through all eight slots
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= 3'd0;
      active   <= 1'b0;
      wbstar_q <= 32'h0;
    end else if (start) begin
      idx      <= 3'd0;
      active   <= 1'b1;
      wbstar_q <= wbstar;
    end else if (active) begin
      if (idx == 3'd7) begin
        active <= 1'b0;
      end else begin
        idx <= idx + 3'd1;
      end
    end
  end

  // Select the command word for the current slot
  always_comb begin
    word = DUMMY;
    case (idx)
      3'd0: word = DUMMY;
      3'd1: word = SYNC;
      3'd2: word = NOOP;
      3'd3: word = WR_WBSTAR;
      3'd4: word = wbstar_q;
      3'd5: word = NOOP;
      3'd6: word = WR_CMD;
      3'd7: word = CMD_IPROG;
      default: word = DUMMY;
    endcase
  end

  assign valid = active;
  assign done  = active && (idx == 3'd7);

endmodule

// File: rtl/icap_arbiter.sv
// Round-robin burst arbiter owning the ICAPE3 port, with a non-maskable IPROG path.
module icap_arbiter
  import icap_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int STALL_MAX = 64
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_valid,
  input  logic [63:0] s_data,
  input  logic [1:0]  s_last,
  output logic [1:0]  s_ready,
  input  logic        iprog_req,
  input  logic [31:0] wbstar,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        iprog_done,
  output logic        icap_csib,
  output logic        icap_rdwrb,
  output logic [31:0] icap_i
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  state_t      state;
  logic [1:0]  grant_q;
  logic        rr_ptr;
  logic [7:0]  word_cnt;
  logic [7:0]  stall_cnt;
  logic        csib_q;
  logic        rdwrb_q;
  logic [31:0] data_q;
  logic        done_q;

  logic [1:0]  acc_vec;
  logic        accept;
  logic        sel_last;
  logic [31:0] sel_data;
  logic        any_valid;
  logic        pick;
  logic        arb_point;
  logic        start_iprog;
  logic [31:0] seq_word;
  logic        seq_valid;
  logic        seq_done;

  icap_iprog_seq u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start_iprog),
    .wbstar  (wbstar),
    .word    (seq_word),
    .valid   (seq_valid),
    .done    (seq_done)
  );

  // Decode the accepted word and the round-robin winner for this cycle
  always_comb begin
    acc_vec     = s_valid & grant_q;
    accept      = |acc_vec;
    sel_last    = |(acc_vec & s_last);
    sel_data    = grant_q[1] ? s_data[63:32] : s_data[31:0];
    any_valid   = |s_valid;
    pick        = s_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    arb_point   = (state == ST_IDLE) || (state == ST_GAP);
    start_iprog = arb_point && iprog_req;
  end

  // Arbiter FSM with burst/stall counters and the registered ICAPE3 drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      grant_q   <= 2'b00;
      rr_ptr    <= 1'b0;
      word_cnt  <= 8'd0;
      stall_cnt <= 8'd0;
      csib_q    <= 1'b1;
      rdwrb_q   <= 1'b1;
      data_q    <= 32'hFFFF_FFFF;
      done_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          csib_q  <= 1'b1;
          rdwrb_q <= 1'b1;
          grant_q <= 2'b00;
          if (iprog_req) begin
            state <= ST_IPROG;
          end else if (any_valid) begin
            grant_q   <= pick ? 2'b10 : 2'b01;
            rr_ptr    <= ~pick;
            word_cnt  <= 8'd0;
            stall_cnt <= 8'd0;
            state     <= ST_XFER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          rdwrb_q <= 1'b0;
          if (accept) begin
            data_q    <= bitswap32(sel_data);
            csib_q    <= 1'b0;
            stall_cnt <= 8'd0;
            word_cnt  <= word_cnt + 8'd1;
            if (sel_last || (word_cnt == BURST_LAST)) begin
              grant_q <= 2'b00;
              state   <= ST_GAP;
            end
          end else begin
            csib_q <= 1'b1;
            if (stall_cnt == STALL_LAST) begin
              grant_q <= 2'b00;
              state   <= ST_GAP;
            end else begin
              stall_cnt <= stall_cnt + 8'd1;
            end
          end
        end
        ST_IPROG: begin
          if (seq_valid) begin
            data_q  <= bitswap32(seq_word);
            csib_q  <= 1'b0;
            rdwrb_q <= 1'b0;
            if (seq_done) begin
              done_q <= 1'b1;
              state  <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          csib_q  <= 1'b1;
          rdwrb_q <= 1'b1;
          grant_q <= 2'b00;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = grant_q;
  assign grant      = grant_q;
  assign busy       = (state != ST_IDLE);
  assign iprog_done = done_q;
  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_i     = data_q;

endmodule

// File: tb/tb_icap_arbiter.sv
// Directed bench for icap_arbiter: arbitration, burst splitting, stall release, IPROG and reset.
module tb_icap_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_valid = 2'b00;
  logic [63:0] s_data = 64'h0;
  logic [1:0]  s_last = 2'b00;
  logic [1:0]  s_ready;
  logic        iprog_req = 1'b0;
  logic [31:0] wbstar = 32'h0;
  logic [1:0]  grant;
  logic        busy;
  logic        iprog_done;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_i;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic        csib;
    logic        rdwrb;
    logic [31:0] i;
    logic [1:0]  grant;
    logic [1:0]  ready;
    logic [1:0]  acc;
    logic        busy;
    logic        done;
  } obs_t;

  beat_t      q0[$];
  beat_t      q1[$];
  obs_t       log_q[$];
  logic       en0, en1;
  logic [1:0] acc;
  int         tests_run = 0;
  int         tests_failed = 0;

  always #5 clk = ~clk;

  icap_arbiter #(.MAX_BURST(16), .STALL_MAX(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .iprog_req  (iprog_req),
    .wbstar     (wbstar),
    .grant      (grant),
    .busy       (busy),
    .iprog_done (iprog_done),
    .icap_csib  (icap_csib),
    .icap_rdwrb (icap_rdwrb),
    .icap_i     (icap_i)
  );

  // One cycle: retire words taken at the last edge, log outputs, present next words
  task automatic tick();
    obs_t o;
    @(negedge clk);
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    s_valid[0]     = en0 && (q0.size() > 0);
    s_valid[1]     = en1 && (q1.size() > 0);
    s_data[31:0]   = (q0.size() > 0) ? q0[0].data : 32'h0;
    s_data[63:32]  = (q1.size() > 0) ? q1[0].data : 32'h0;
    s_last[0]      = (q0.size() > 0) ? q0[0].last : 1'b0;
    s_last[1]      = (q1.size() > 0) ? q1[0].last : 1'b0;
    acc            = s_valid & s_ready;
    o.csib  = icap_csib;
    o.rdwrb = icap_rdwrb;
    o.i     = icap_i;
    o.grant = grant;
    o.ready = s_ready;
    o.acc   = acc;
    o.busy  = busy;
    o.done  = iprog_done;
    log_q.push_back(o);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    s_valid   = 2'b00;
    s_data    = 64'h0;
    s_last    = 2'b00;
    iprog_req = 1'b0;
    en0 = 1'b0;
    en1 = 1'b0;
    acc = 2'b00;
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    log_q.delete();
  endtask

  task automatic test_reset();
    logic bad;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({icap_csib, icap_rdwrb, icap_i} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("[TB] FAIL reset_icap: got csib=%b rdwrb=%b i=%h, want 1 1 ffffffff", icap_csib, icap_rdwrb, icap_i);
    end
    tests_run++;
    if ({s_ready, grant, busy, iprog_done} !== 6'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: got ready=%b grant=%b busy=%b done=%b, want all 0", s_ready, grant, busy, iprog_done);
    end
    do_reset();
    ticks(4);
    bad = 1'b0;
    foreach (log_q[k]) if (log_q[k].busy !== 1'b0 || log_q[k].csib !== 1'b1) bad = 1'b1;
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_idle: idle bus disturbed (got bad=%b, want 0)", bad);
    end
  endtask

  task automatic test_single_burst();
    logic [31:0] exp_w[3];
    exp_w = '{32'h0400_0000, 32'h0C00_0180, 32'h0000_00E0};
    do_reset();
    q0.push_back('{1'b0, 32'h2000_0000});
    q0.push_back('{1'b0, 32'h3000_8001});
    q0.push_back('{1'b1, 32'h0000_0007});
    en0 = 1'b1;
    ticks(7);
    tests_run++;
    if ({log_q[1].grant, log_q[1].ready} !== 4'b0101) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: got grant=%b ready=%b, want 01 01", log_q[1].grant, log_q[1].ready);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({log_q[2+k].csib, log_q[2+k].rdwrb, log_q[2+k].i} !== {2'b00, exp_w[k]}) begin
        tests_failed++;
        $display("[TB] FAIL single_word%0d: got csib=%b rdwrb=%b i=%h, want 0 0 %h", k,
                 log_q[2+k].csib, log_q[2+k].rdwrb, log_q[2+k].i, exp_w[k]);
      end
    end
    tests_run++;
    if ({log_q[4].grant, log_q[4].ready, log_q[4].busy} !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL single_gapstate: got grant=%b ready=%b busy=%b, want 00 00 1",
               log_q[4].grant, log_q[4].ready, log_q[4].busy);
    end
    tests_run++;
    if ({log_q[5].csib, log_q[5].rdwrb, log_q[6].csib, log_q[6].busy} !== 4'b1110) begin
      tests_failed++;
      $display("[TB] FAIL single_gap: got gap csib=%b rdwrb=%b, idle csib=%b busy=%b, want 1 1 1 0",
               log_q[5].csib, log_q[5].rdwrb, log_q[6].csib, log_q[6].busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] runs[$];
    int         gaps[$];
    logic [1:0] exp_runs[4];
    logic [1:0] prev;
    logic [1:0] got;
    int         zeros;
    int         words;
    exp_runs = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int b = 0; b < 2; b++) begin
      q0.push_back('{1'b0, 32'h0000_0010 + b});
      q0.push_back('{1'b1, 32'h0000_0020 + b});
      q1.push_back('{1'b0, 32'h0000_0030 + b});
      q1.push_back('{1'b1, 32'h0000_0040 + b});
    end
    en0 = 1'b1;
    en1 = 1'b1;
    ticks(20);
    prev  = 2'b00;
    zeros = 0;
    words = 0;
    foreach (log_q[k]) begin
      if (log_q[k].csib == 1'b0) words++;
      if (log_q[k].grant != 2'b00) begin
        if (log_q[k].grant != prev) begin
          if (runs.size() > 0) gaps.push_back(zeros);
          runs.push_back(log_q[k].grant);
        end
        zeros = 0;
      end else begin
        zeros++;
      end
      prev = log_q[k].grant;
    end
    for (int k = 0; k < 4; k++) begin
      got = (k < runs.size()) ? runs[k] : 2'bxx;
      tests_run++;
      if (got !== exp_runs[k]) begin
        tests_failed++;
        $display("[TB] FAIL b2b_grant%0d: got %b, want %b", k, got, exp_runs[k]);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= gaps.size() || gaps[k] != 1) begin
        tests_failed++;
        $display("[TB] FAIL b2b_gap%0d: got %0d idle cycles, want 1", k, (k < gaps.size()) ? gaps[k] : -1);
      end
    end
    tests_run++;
    if (words != 8) begin
      tests_failed++;
      $display("[TB] FAIL b2b_words: got %0d words, want 8", words);
    end
  endtask

  task automatic test_max_burst();
    logic [1:0] runs[$];
    int         cnts[$];
    logic [1:0] exp_runs[3];
    int         exp_cnts[3];
    logic [1:0] prev;
    exp_runs = '{2'b10, 2'b01, 2'b10};
    exp_cnts = '{16, 1, 4};
    do_reset();
    for (int k = 0; k < 20; k++) q1.push_back('{1'b0, 32'h0100_0000 + k});
    q0.push_back('{1'b1, 32'hCAFE_0000});
    en1 = 1'b1;
    ticks(3);
    en0 = 1'b1;
    ticks(97);
    prev = 2'b00;
    foreach (log_q[k]) begin
      if (log_q[k].grant != 2'b00 && log_q[k].grant != prev) begin
        runs.push_back(log_q[k].grant);
        cnts.push_back(0);
      end
      if ((log_q[k].acc & log_q[k].grant) != 2'b00) cnts[cnts.size()-1]++;
      prev = log_q[k].grant;
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (k >= runs.size() || runs[k] !== exp_runs[k] || cnts[k] != exp_cnts[k]) begin
        tests_failed++;
        $display("[TB] FAIL maxburst_run%0d: got grant=%b words=%0d, want %b %0d", k,
                 (k < runs.size()) ? runs[k] : 2'bxx, (k < cnts.size()) ? cnts[k] : -1,
                 exp_runs[k], exp_cnts[k]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    q0.push_back('{1'b0, 32'h1111_1111});
    q1.push_back('{1'b1, 32'h2222_2222});
    en0 = 1'b1;
    en1 = 1'b1;
    ticks(75);
    tests_run++;
    if ({log_q[65].grant, log_q[65].csib, log_q[65].rdwrb} !== 4'b0110) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got grant=%b csib=%b rdwrb=%b, want 01 1 0",
               log_q[65].grant, log_q[65].csib, log_q[65].rdwrb);
    end
    tests_run++;
    if (log_q[66].grant !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: got grant=%b, want 00", log_q[66].grant);
    end
    tests_run++;
    if ({log_q[67].grant, log_q[67].acc} !== 4'b1010) begin
      tests_failed++;
      $display("[TB] FAIL stall_next: got grant=%b acc=%b, want 10 10", log_q[67].grant, log_q[67].acc);
    end
  endtask

  task automatic test_iprog();
    logic [31:0] exp_w[11];
    int          idx[$];
    logic        leak;
    exp_w = '{32'h0400_0000, 32'h0C00_0180, 32'h0000_00E0,
              32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000, 32'h0C40_0080,
              32'h0002_0000, 32'h0400_0000, 32'h0C00_0180, 32'h0000_00F0};
    do_reset();
    wbstar = 32'h0040_0000;
    q0.push_back('{1'b0, 32'h2000_0000});
    q0.push_back('{1'b0, 32'h3000_8001});
    q0.push_back('{1'b1, 32'h0000_0007});
    q0.push_back('{1'b0, 32'h5555_5555});
    q0.push_back('{1'b1, 32'h6666_6666});
    en0 = 1'b1;
    ticks(3);
    iprog_req = 1'b1;
    ticks(32);
    foreach (log_q[k]) if (log_q[k].csib == 1'b0) idx.push_back(k);
    tests_run++;
    if (idx.size() != 11) begin
      tests_failed++;
      $display("[TB] FAIL iprog_count: got %0d words, want 11", idx.size());
    end else begin
      for (int k = 0; k < 11; k++) begin
        tests_run++;
        if (log_q[idx[k]].i !== exp_w[k]) begin
          tests_failed++;
          $display("[TB] FAIL iprog_word%0d: got %h, want %h", k, log_q[idx[k]].i, exp_w[k]);
        end
      end
      tests_run++;
      if (idx[3] - idx[2] != 2 || {log_q[idx[2]+1].csib, log_q[idx[2]+1].rdwrb} !== 2'b11 || idx[10] - idx[3] != 7) begin
        tests_failed++;
        $display("[TB] FAIL iprog_timing: got gap=%0d span=%0d, want 2 7", idx[3] - idx[2], idx[10] - idx[3]);
      end
      tests_run++;
      if ({log_q[idx[3]].done, log_q[idx[10]].done} !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL iprog_done: got first=%b last=%b, want 0 1", log_q[idx[3]].done, log_q[idx[10]].done);
      end
      leak = 1'b0;
      for (int k = idx[10]; k < log_q.size(); k++)
        if (log_q[k].ready !== 2'b00 || log_q[k].grant !== 2'b00 || log_q[k].done !== 1'b1) leak = 1'b1;
      tests_run++;
      if (leak !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL iprog_halt: ready/grant/done disturbed after sequence (got %b, want 0)", leak);
      end
    end
    tests_run++;
    if ({icap_csib, icap_rdwrb, busy, iprog_done} !== 4'b1111) begin
      tests_failed++;
      $display("[TB] FAIL iprog_haltbus: got csib=%b rdwrb=%b busy=%b done=%b, want 1111", icap_csib, icap_rdwrb, busy, iprog_done);
    end
  endtask

  task automatic test_reset_in_iprog();
    logic bad;
    do_reset();
    wbstar    = 32'h0040_0000;
    iprog_req = 1'b1;
    ticks(5);
    tests_run++;
    if ({log_q[4].csib, log_q[4].i} !== {1'b0, 32'h0C40_0080}) begin
      tests_failed++;
      $display("[TB] FAIL rstiprog_word4: got csib=%b i=%h, want 0 0c400080", log_q[4].csib, log_q[4].i);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({icap_csib, icap_rdwrb, icap_i, s_ready, grant, busy, iprog_done} !== {2'b11, 32'hFFFF_FFFF, 6'b0}) begin
      tests_failed++;
      $display("[TB] FAIL rstiprog_async: got csib=%b rdwrb=%b i=%h ready=%b grant=%b busy=%b done=%b, want 1 1 ffffffff 00 00 0 0",
               icap_csib, icap_rdwrb, icap_i, s_ready, grant, busy, iprog_done);
    end
    iprog_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    log_q.delete();
    ticks(12);
    bad = 1'b0;
    foreach (log_q[k]) if (log_q[k].csib !== 1'b1 || log_q[k].busy !== 1'b0 || log_q[k].done !== 1'b0) bad = 1'b1;
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstiprog_idle: sequence resumed or not idle (got %b, want 0)", bad);
    end
  endtask

  initial begin
    en0 = 1'b0;
    en1 = 1'b0;
    acc = 2'b00;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_max_burst();
    test_stall();
    test_iprog();
    test_reset_in_iprog();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
